// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit toy CPU control path: opcodes, FSM state
// encoding (also shown on the seven-segment display) and instruction field positions.
package cpu8_pkg;

  // Opcodes held in ir[7:6]
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Control FSM states; the numeric values are visible on state_dbg
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_PAUSE  = 3'd5;

  // Instruction field slice positions
  localparam int IR_OP_HI = 7;
  localparam int IR_OP_LO = 6;
  localparam int IR_RS_HI = 5;
  localparam int IR_RS_LO = 4;
  localparam int IR_RT_HI = 3;
  localparam int IR_RT_LO = 2;
  localparam int IR_RD_HI = 1;
  localparam int IR_RD_LO = 0;

  // Decoded instruction class plus the register the result goes to
  typedef struct packed {
    logic       is_add;
    logic       is_lw;
    logic       is_sw;
    logic       is_j;
    logic [1:0] wb_addr;
  } dec_t;

  function automatic logic [1:0] ir_op(input logic [7:0] ir);
    return ir[IR_OP_HI:IR_OP_LO];
  endfunction

endpackage

// File: rtl/cpu8_decode.sv
// Combinational instruction decoder: opcode class flags, writeback register
// selection (add writes rd, lw writes rt) and the sign-extended jump offset.
module cpu8_decode
  import cpu8_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [7:0]      ir_i,
  output dec_t            dec_o,
  output logic [PC_W-1:0] imm_o
);

  logic [1:0] op;
  logic [1:0] rs_unused;

  // Decode the latched instruction into class flags, destination and offset
  always_comb begin
    op        = ir_op(ir_i);
    rs_unused = ir_i[IR_RS_HI:IR_RS_LO];

    dec_o.is_add = (op == OP_ADD);
    dec_o.is_lw  = (op == OP_LW);
    dec_o.is_sw  = (op == OP_SW);
    dec_o.is_j   = (op == OP_J);

    if (op == OP_LW) begin
      dec_o.wb_addr = ir_i[IR_RT_HI:IR_RT_LO];
    end else begin
      dec_o.wb_addr = ir_i[IR_RD_HI:IR_RD_LO];
    end

    // Two-bit immediate sign-extended to the pc width (range -2..+1)
    imm_o = {{(PC_W-2){ir_i[IR_RD_HI]}}, ir_i[IR_RD_HI:IR_RD_LO]};
  end

endmodule

// File: rtl/cpu8_multicycle_ctrl.sv
// Multi-cycle control FSM of the toy CPU. Fetches one ROM byte per instruction,
// sequences decode / execute / memory / writeback, bounds memory waits with a
// timeout that sets a sticky error, and supports single-step via a PAUSE state.
module cpu8_multicycle_ctrl
  import cpu8_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk50,
  input  logic            reset,
  input  logic [7:0]      instr,
  input  logic            step_mode,
  input  logic            step,
  input  logic            mem_ack,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic            reg_we,
  output logic            wb_sel,
  output logic [1:0]      wb_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic            retire,
  output logic            mem_err,
  output logic [2:0]      state_dbg
);

  // Last MEM wait index before giving up (counter is 4 bits wide)
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0]      tmo_cnt_q, tmo_cnt_d;
  logic            mem_err_q, mem_err_d;

  dec_t            dec;
  logic [PC_W-1:0] imm;
  logic [PC_W-1:0] next_pc;
  logic            retire_c;
  logic            reg_we_c;
  logic            mem_req_c;

  cpu8_decode #(
    .PC_W (PC_W)
  ) u_decode (
    .ir_i  (ir_q),
    .dec_o (dec),
    .imm_o (imm)
  );

  // Next-state logic: one case arm per state, retire handled uniformly afterwards
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    tmo_cnt_d = tmo_cnt_q;
    mem_err_d = mem_err_q;
    retire_c  = 1'b0;
    reg_we_c  = 1'b0;
    mem_req_c = 1'b0;

    // Jumps add the signed offset on top of the normal increment; wraps mod 2^PC_W
    next_pc = pc_q + PC_W'(1) + (dec.is_j ? imm : '0);

    case (state_q)
      ST_FETCH: begin
        ir_d    = instr;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec.is_j) begin
          retire_c = 1'b1;
        end else if (dec.is_add) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          tmo_cnt_d = '0;
          if (dec.is_lw) begin
            state_d = ST_WB;
          end else begin
            retire_c = 1'b1;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Give up: flag the error and retire without any register write
          tmo_cnt_d = '0;
          mem_err_d = 1'b1;
          retire_c  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
      end
      ST_WB: begin
        reg_we_c = 1'b1;
        retire_c = 1'b1;
      end
      ST_PAUSE: begin
        if (step || !step_mode) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (retire_c) begin
      pc_d    = next_pc;
      state_d = step_mode ? ST_PAUSE : ST_FETCH;
    end
  end

  // Architectural state registers with asynchronous board reset
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      tmo_cnt_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      tmo_cnt_q <= tmo_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign reg_we    = reg_we_c;
  assign wb_sel    = reg_we_c & dec.is_lw;
  assign wb_addr   = reg_we_c ? dec.wb_addr : 2'b00;
  assign mem_req   = mem_req_c;
  assign mem_we    = mem_req_c & dec.is_sw;
  assign retire    = retire_c;
  assign mem_err   = mem_err_q;
  assign state_dbg = state_q;

endmodule
